// File: rtl/sensor_conditioner.sv
// Vehicle-detector conditioning: 2-flop sync, debounce, hold-stretch FSM, saturating arrival count.
// Optional stuck-presence detector is built when SENSOR_COND_STUCK_DET_EN is defined.
module sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1000,
    parameter int CWIDTH          = 16,
    parameter int COUNT_BITS      = 16,
    parameter int STUCK_CYCLES    = 60000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  raw_sensor,
    input  logic                  clear,
    output logic                  sensor,
    output logic                  arrival,
    output logic [COUNT_BITS-1:0] vehicle_count,
    output logic                  stuck
);

    typedef enum logic [1:0] {IDLE, PRESENT, HOLD} state_t;

    localparam logic [CWIDTH-1:0]     ONE       = CWIDTH'(1);
    localparam logic [COUNT_BITS-1:0] COUNT_ONE = COUNT_BITS'(1);
    localparam logic [CWIDTH-1:0]     DEB_LAST  = CWIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CWIDTH-1:0]     HOLD_LAST = CWIDTH'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam int MAX_CNT = (DEBOUNCE_CYCLES > HOLD_CYCLES)
                           ? ((DEBOUNCE_CYCLES > STUCK_CYCLES) ? DEBOUNCE_CYCLES : STUCK_CYCLES)
                           : ((HOLD_CYCLES > STUCK_CYCLES) ? HOLD_CYCLES : STUCK_CYCLES);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("sensor_conditioner: DEBOUNCE_CYCLES must be at least 1");
    end
    if (longint'(MAX_CNT) >= (longint'(1) << CWIDTH)) begin : g_bad_cwidth
        $error("sensor_conditioner: CWIDTH too narrow for the configured cycle counts");
    end

    function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
        return (&v) ? v : v + COUNT_ONE;
    endfunction

    logic              s1, s2, deb;
    logic [CWIDTH-1:0] dcnt;
    logic [CWIDTH-1:0] hcnt, hcnt_nxt;
    state_t            state, state_nxt;
    logic              entering;

    // Stage: synchronizer and debounce
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            deb  <= 1'b0;
            dcnt <= '0;
        end else begin
            s1 <= raw_sensor;
            s2 <= s1;
            if (s2 != deb) begin
                if (dcnt == DEB_LAST) begin
                    deb  <= ~deb;
                    dcnt <= '0;
                end else begin
                    dcnt <= dcnt + ONE;
                end
            end else begin
                dcnt <= '0;
            end
        end
    end

    // Stage: presence/hold FSM; re-arrival in HOLD takes priority over clear and expiry
    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        case (state)
            IDLE: begin
                if (deb) state_nxt = PRESENT;
            end
            PRESENT: begin
                if (!deb) begin
                    state_nxt = (HOLD_CYCLES == 0) ? IDLE : HOLD;
                    hcnt_nxt  = '0;
                end
            end
            HOLD: begin
                if (deb)                    state_nxt = PRESENT;
                else if (clear)             state_nxt = IDLE;
                else if (hcnt == HOLD_LAST) state_nxt = IDLE;
                else                        hcnt_nxt  = hcnt + ONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign entering = (state_nxt == PRESENT) && (state != PRESENT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            hcnt          <= '0;
            arrival       <= 1'b0;
            vehicle_count <= '0;
        end else begin
            state   <= state_nxt;
            hcnt    <= hcnt_nxt;
            arrival <= entering;
            if (entering) vehicle_count <= sat_inc(vehicle_count);
        end
    end

`ifdef SENSOR_COND_STUCK_DET_EN
    localparam logic [CWIDTH-1:0] STUCK_LAST = CWIDTH'(STUCK_CYCLES - 1);
    logic [CWIDTH-1:0] scnt;

    // Stage: stuck detector; a new stuck event outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scnt  <= '0;
            stuck <= 1'b0;
        end else begin
            scnt <= (state == PRESENT) ? scnt + ONE : '0;
            if ((state == PRESENT) && (scnt == STUCK_LAST)) stuck <= 1'b1;
            else if (clear)                                 stuck <= 1'b0;
        end
    end
`else
    assign stuck = 1'b0;
`endif

    assign sensor = (state != IDLE) || stuck;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed plus randomized bench for sensor_conditioner against a behavioural model of the
// detector rules; mirrors SENSOR_COND_STUCK_DET_EN to know whether stuck detection is built.
module tb_sensor_conditioner;

    localparam int D  = 4;
    localparam int H  = 8;
    localparam int CW = 16;
    localparam int CB = 2;
    localparam int SC = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic          raw_sensor;
    logic          clear;
    logic          sensor;
    logic          arrival;
    logic          stuck;
    logic [CB-1:0] vehicle_count;

    always #5 clk = ~clk;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .CWIDTH         (CW),
        .COUNT_BITS     (CB),
        .STUCK_CYCLES   (SC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .raw_sensor   (raw_sensor),
        .clear        (clear),
        .sensor       (sensor),
        .arrival      (arrival),
        .vehicle_count(vehicle_count),
        .stuck        (stuck)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: the detector sees raw two edges late, accepts a level after D
    // disagreeing samples, is "present" one edge after the accepted level is high, and then
    // keeps the request alive for H more edges unless cleared or re-arrived.
    bit m_s1, m_s2, m_deb, m_present, m_arrival, m_stuck;
    int m_hold, m_count, m_plen;
    bit hist[$];

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_present = 0; m_arrival = 0; m_stuck = 0;
        m_hold = 0; m_count = 0; m_plen = 0;
        hist.delete();
        for (int i = 0; i < D; i++) hist.push_back(1'b0);
    endtask

    task automatic model_edge();
        bit s2_old, deb_old, pres_old, all_diff;
        int plen_old;
        s2_old   = m_s2;
        deb_old  = m_deb;
        pres_old = m_present;
        plen_old = m_plen;
        m_s2 = m_s1;
        m_s1 = raw_sensor;
        hist.push_back(s2_old);
        if (hist.size() > D) void'(hist.pop_front());
        all_diff = 1;
        foreach (hist[i]) if (hist[i] == deb_old) all_diff = 0;
        if (all_diff) m_deb = !deb_old;
        m_arrival = deb_old && !pres_old;
        if (m_arrival && m_count < (1 << CB) - 1) m_count++;
        if (deb_old) begin
            m_present = 1; m_hold = 0;
        end else if (pres_old) begin
            m_present = 0; m_hold = H;
        end else if (m_hold > 0) begin
            m_hold = clear ? 0 : m_hold - 1;
        end
        m_plen = m_present ? (pres_old ? plen_old + 1 : 1) : 0;
`ifdef SENSOR_COND_STUCK_DET_EN
        if (pres_old && plen_old == SC) m_stuck = 1;
        else if (clear)                 m_stuck = 0;
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("sensor", sensor, (m_present || m_hold > 0 || m_stuck) ? 1 : 0);
        chk("arrival", arrival, m_arrival);
        chk("vehicle_count", vehicle_count, m_count);
        chk("stuck", stuck, m_stuck);
    endtask

    int arr_seen;
    bit sensor_seen, sensor_dropped;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
            if (arrival === 1'b1) arr_seen++;
            if (sensor === 1'b1) sensor_seen = 1;
            if (sensor !== 1'b1) sensor_dropped = 1;
        end
    endtask

    int sat_seq[5] = '{1, 2, 3, 3, 3};

    initial begin
        rst = 1'b0; raw_sensor = 1'b0; clear = 1'b0;
        model_reset();
        #12;
        chk("reset_sensor", sensor, 0);
        chk("reset_arrival", arrival, 0);
        chk("reset_count", vehicle_count, 0);
        chk("reset_stuck", stuck, 0);
        @(negedge clk);
        rst = 1'b1;
        step(5);

        // First arrival: request appears D+2 edges after raw is first sampled
        raw_sensor = 1'b1;
        step(D + 2);
        chk("rise_not_yet", sensor, 0);
        step(1);
        chk("rise_sensor", sensor, 1);
        chk("rise_arrival", arrival, 1);
        chk("rise_count", vehicle_count, 1);
        step(1);
        chk("arrival_width", arrival, 0);
        step(12);

        // Departure: accepted level falls D+1 edges later, request lasts 1+H more edges
        raw_sensor = 1'b0;
        step(14);
        chk("hold_still_high", sensor, 1);
        step(1);
        chk("hold_expired", sensor, 0);
        step(5);

        // Short glitches never qualify
        sensor_seen = 0;
        for (int g = 0; g < 4; g++) begin
            raw_sensor = 1'b1; step(3);
            raw_sensor = 1'b0; step(7);
        end
        chk("glitch_sensor", sensor_seen, 0);
        chk("glitch_count", vehicle_count, 1);

        // Re-arrival during HOLD keeps the request up and counts again
        raw_sensor = 1'b1; step(20);
        chk("second_count", vehicle_count, 2);
        sensor_dropped = 0;
        raw_sensor = 1'b0; step(6);
        raw_sensor = 1'b1; step(20);
        chk("rearrival_no_drop", sensor_dropped, 0);
        chk("rearrival_count", vehicle_count, 3);

        // Clear during HOLD drops the request on the next edge
        raw_sensor = 1'b0; step(8);
        chk("pre_clear_high", sensor, 1);
        clear = 1'b1; step(1);
        clear = 1'b0;
        chk("clear_in_hold", sensor, 0);
        step(4);

        // Asynchronous reset in the middle of HOLD
        raw_sensor = 1'b1; step(12);
        raw_sensor = 1'b0; step(9);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_sensor", sensor, 0);
        chk("async_rst_arrival", arrival, 0);
        chk("async_rst_count", vehicle_count, 0);
        chk("async_rst_stuck", stuck, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(3);

        // Counter saturation on a 2-bit count
        arr_seen = 0;
        for (int k = 0; k < 5; k++) begin
            raw_sensor = 1'b1; step(D + 3);
            chk("sat_count", vehicle_count, sat_seq[k]);
            step(5);
            raw_sensor = 1'b0; step(20);
        end
        chk("sat_arrivals", arr_seen, 5);

        // Continuous presence: stuck detector (or its absence)
        raw_sensor = 1'b1; step(D + 3);
        step(SC - 1);
        chk("stuck_before", stuck, 0);
        step(1);
`ifdef SENSOR_COND_STUCK_DET_EN
        chk("stuck_set", stuck, 1);
        raw_sensor = 1'b0; step(30);
        chk("stuck_failsafe", sensor, 1);
        clear = 1'b1; step(1);
        clear = 1'b0;
        chk("stuck_cleared", stuck, 0);
        chk("stuck_clear_sensor", sensor, 0);
`else
        chk("stuck_absent", stuck, 0);
        raw_sensor = 1'b0; step(30);
        chk("no_failsafe", sensor, 0);
`endif
        step(3);

        // Randomized run-length stimulus with sporadic clear
        for (int r = 0; r < 150; r++) begin
            int len;
            raw_sensor = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            for (int c = 0; c < len; c++) begin
                clear = ($urandom_range(0, 19) == 0);
                step(1);
            end
        end
        clear = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Conditions the raw roadside vehicle-detector input into the clean `sensor` request consumed by the traffic-light controller and its PWM lamp stage. Processing chain: two-flop synchronizer, debounce, stretch, and saturating vehicle counting. A stretch FSM holds the request for a minimum time after the vehicle leaves, so short detections are never lost between controller phase decisions.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles needed to accept a level change; must be ≥1.
- `HOLD_CYCLES`, 1000: cycles `sensor` stays high after the debounced input falls; 0 = no stretch.
- `CWIDTH`, 16: width of the debounce, hold and stuck counters; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES, STUCK_CYCLES).
- `COUNT_BITS`, 16: width of `vehicle_count`.
- `STUCK_CYCLES`, 60000: continuous-presence limit; used only under `SENSOR_COND_STUCK_DET_EN`.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `raw_sensor` in 1: asynchronous detector input.
- `clear` in 1: synchronous; aborts the hold and clears `stuck`.
- `sensor` out 1: conditioned request to the controller.
- `arrival` out 1: one-cycle pulse per accepted vehicle.
- `vehicle_count` out COUNT_BITS: saturating count of accepted vehicles.
- `stuck` out 1: sticky stuck-detector flag.

## Operation
- Reset values: all flops 0, FSM in IDLE, and all outputs 0.
- Synchronizer: `s1 <= raw_sensor`, `s2 <= s1`.
- Debounce:
  - `deb` is the accepted level.
  - `dcnt` increments each cycle that `s2 != deb` and clears to 0 each cycle that `s2 == deb`.
  - When `s2 != deb` and `dcnt == DEBOUNCE_CYCLES-1`, `deb` toggles and `dcnt` clears on that edge.
- FSM states: IDLE, PRESENT, HOLD. `sensor` = (state != IDLE) OR `stuck`.
  - IDLE: if `deb`, go to PRESENT.
  - PRESENT: if `!deb`, go to HOLD (or to IDLE when HOLD_CYCLES=0); `hcnt` is loaded with 0.
  - HOLD:
    - if `deb`, go to PRESENT (re-arrival wins over `clear` and over expiry);
    - else if `clear`, go to IDLE;
    - else if `hcnt == HOLD_CYCLES-1`, go to IDLE;
    - else `hcnt` increments.
  - `clear` in IDLE or PRESENT has no effect on state.
- Arrival:
  - `arrival` is registered, 1 on the cycle the FSM enters PRESENT from IDLE or HOLD.
  - On the same edge, `vehicle_count` increments unless it is all-ones, where it holds (no wrap).
- Reset asserted mid-operation: everything returns to reset values immediately; no partial counts survive.

## Timing
- Raw rise sampled at edge E0 → `s2` at E1 → `deb` at E1+DEBOUNCE_CYCLES → `sensor`/`arrival` at E0+DEBOUNCE_CYCLES+2.
- A glitch shorter than DEBOUNCE_CYCLES cycles at `s2` never reaches `deb`.
- Fall latency to `deb` equals rise latency. `sensor` then stays high for 1 (PRESENT→HOLD edge) + HOLD_CYCLES cycles before IDLE.
- `clear` sampled high in HOLD: `sensor` low on the next edge.
- `arrival` width is always exactly 1 cycle; consecutive pulses are at least DEBOUNCE_CYCLES·2 cycles apart.

## Configuration
- `SENSOR_COND_STUCK_DET_EN` defined:
  - `scnt` counts consecutive cycles in PRESENT and clears whenever the state is not PRESENT.
  - At `scnt == STUCK_CYCLES-1`, `stuck` sets and stays set until `clear` or reset.
  - While `stuck` is set, `sensor` is forced to 1 (fail-safe service) and `arrival`/`vehicle_count` still operate normally.
  - `clear` and a new stuck event on the same cycle: the set wins.
- Not defined: no `scnt` logic; `stuck` is tied to 0.

## Test plan
- DEBOUNCE_CYCLES=4, HOLD_CYCLES=8: raw high at edge 10 for 20 cycles → `sensor` and `arrival` high at edge 16, `vehicle_count`=1, `arrival` low at edge 17.
- Same config, raw pulses of 3 cycles every 10 cycles → `sensor` stays 0 and `vehicle_count` stays 0.
- Raw high 20 cycles, then low → `sensor` falls exactly 9 cycles after `deb` falls. Repeat with raw re-high during HOLD → FSM returns to PRESENT, `sensor` never drops, count increments to 2.
- In HOLD, pulse `clear` for 1 cycle → `sensor` 0 on next edge. Assert `rst` low mid-HOLD → `sensor`, `arrival`, `vehicle_count`, `stuck` all 0 asynchronously.
- COUNT_BITS=2, 5 debounced arrivals → `vehicle_count` reads 1, 2, 3, 3, 3; five `arrival` pulses.
- With `SENSOR_COND_STUCK_DET_EN`, STUCK_CYCLES=50: raw held high → `stuck`=1 after 50 cycles in PRESENT. Drop raw → `sensor` stays 1 past hold expiry; `clear` → `stuck` and `sensor` return to 0.
